// File: rtl/stage_sequencer_pkg.sv
// Shared architecture defines for the core control path: stage encodings
// for the default five-stage core and the default done-handshake mask.
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        STAGE_RESET           = 3'd0,
        STAGE_FETCH           = 3'd1,
        STAGE_DECODE          = 3'd2,
        STAGE_EXECUTE         = 3'd3,
        STAGE_MEMORY          = 3'd4,
        STAGE_REGISTER_UPDATE = 3'd5,
        STAGE_HALT            = 3'd7
    } stage_e;

    localparam int DEFAULT_NUM_STAGES = 5;
    localparam int DEFAULT_STAGE_W    = 3;
    localparam int DEFAULT_CNT_W      = 8;

    // FETCH and MEMORY wait for their units to report completion.
    localparam logic [4:0] DEFAULT_WAIT_MASK = 5'b01001;

endpackage

// File: rtl/stage_sequencer_next_select.sv
// Priority search for the successor stage: the lowest stage index above the
// current one that is not skipped. When none remains the instruction is
// complete and the wrap flag tells the caller to return to FETCH (or park).
module stage_next_select #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_W    = 3
) (
    input  logic [STAGE_W-1:0]    cur_stage,
    input  logic [NUM_STAGES-1:0] skip_mask,
    output logic [STAGE_W-1:0]    next_stage,
    output logic                  wrap
);

    // Stage 1 is the instruction entry point and is never skipped, so the
    // search never looks at bit 0.
    logic unused_skip_fetch;
    assign unused_skip_fetch = skip_mask[0];

    // Scan downward so the last hit is the lowest qualifying index.
    always_comb begin
        next_stage = STAGE_W'(1);
        wrap       = 1'b1;
        for (int t = NUM_STAGES; t >= 2; t--) begin
            if ((STAGE_W'(t) > cur_stage) && !skip_mask[t-1]) begin
                next_stage = STAGE_W'(t);
                wrap       = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Top of the core control path. Walks the core through its stages, pulsing
// start on each stage entry, optionally waiting for a per-stage done,
// skipping stages per instruction, parking in HALT between instructions and
// reporting retire events and the time spent in the current stage.
// NUM_STAGES+2 must fit in 2**STAGE_W so RESET and HALT stay distinct.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int                    NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int                    STAGE_W    = DEFAULT_STAGE_W,
    parameter logic [NUM_STAGES-1:0] WAIT_MASK  = NUM_STAGES'(DEFAULT_WAIT_MASK),
    parameter int                    CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  blocked,
    input  logic [NUM_STAGES-1:0] done,
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic                  halt_req,
    output logic [STAGE_W-1:0]    stage,
    output logic [NUM_STAGES-1:0] start,
    output logic                  retire,
    output logic [CNT_W-1:0]      stage_cycles,
    output logic                  halted
);

    localparam logic [STAGE_W-1:0] ENC_RESET = STAGE_W'(int'(STAGE_RESET));
    localparam logic [STAGE_W-1:0] ENC_FETCH = STAGE_W'(int'(STAGE_FETCH));
    localparam logic [STAGE_W-1:0] ENC_HALT  = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [NUM_STAGES-1:0] done_seen;

    logic [STAGE_W-1:0]    stage_n;
    logic [NUM_STAGES-1:0] start_n;
    logic                  retire_n;
    logic [NUM_STAGES-1:0] done_seen_n;
    logic [CNT_W-1:0]      stage_cycles_n;
    logic                  entering;

    logic                  cur_valid;
    logic                  cur_wait;
    logic                  cur_done;
    logic                  cur_seen;
    logic [NUM_STAGES-1:0] cur_onehot;

    logic [STAGE_W-1:0]    next_stage;
    logic                  wrap;
    logic [NUM_STAGES-1:0] next_onehot;

    stage_next_select #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_W    (STAGE_W)
    ) u_next_select (
        .cur_stage  (stage),
        .skip_mask  (skip_mask),
        .next_stage (next_stage),
        .wrap       (wrap)
    );

    // Decode the current stage into its handshake view (wait, done, latched done).
    always_comb begin
        cur_valid  = 1'b0;
        cur_wait   = 1'b0;
        cur_done   = 1'b0;
        cur_seen   = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage == STAGE_W'(i + 1)) begin
                cur_valid     = 1'b1;
                cur_wait      = WAIT_MASK[i];
                cur_done      = done[i];
                cur_seen      = done_seen[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    // One-hot start vector for the successor stage.
    always_comb begin
        next_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (next_stage == STAGE_W'(i + 1)) begin
                next_onehot[i] = 1'b1;
            end
        end
    end

    // Next stage, pulses and done latch; pulses default low so they self-clear.
    always_comb begin
        stage_n     = stage;
        start_n     = '0;
        retire_n    = 1'b0;
        done_seen_n = done_seen | (cur_onehot & done);
        entering    = 1'b0;

        if (stage == ENC_RESET) begin
            if (!blocked) begin
                stage_n    = ENC_FETCH;
                start_n[0] = 1'b1;
                entering   = 1'b1;
            end
        end else if (cur_valid) begin
            if (!blocked && (!cur_wait || cur_done || cur_seen)) begin
                done_seen_n = '0;
                entering    = 1'b1;
                if (wrap) begin
                    retire_n = 1'b1;
                    if (halt_req) begin
                        stage_n = ENC_HALT;
                    end else begin
                        stage_n    = ENC_FETCH;
                        start_n[0] = 1'b1;
                    end
                end else begin
                    stage_n = next_stage;
                    start_n = next_onehot;
                end
            end
        end else if (stage == ENC_HALT) begin
            if (!halt_req && !blocked) begin
                stage_n    = ENC_FETCH;
                start_n[0] = 1'b1;
                entering   = 1'b1;
            end
        end else begin
            stage_n     = ENC_RESET;
            done_seen_n = '0;
            entering    = 1'b1;
        end
    end

    // Dwell counter restarts on every stage entry and saturates while held.
    always_comb begin
        if (entering || (stage_n == ENC_RESET)) begin
            stage_cycles_n = '0;
        end else if (stage_cycles != CNT_MAX) begin
            stage_cycles_n = stage_cycles + 1'b1;
        end else begin
            stage_cycles_n = stage_cycles;
        end
    end

    // State and registered outputs; low rst wins over everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage        <= ENC_RESET;
            start        <= '0;
            retire       <= 1'b0;
            stage_cycles <= '0;
            done_seen    <= '0;
            halted       <= 1'b0;
        end else begin
            stage        <= stage_n;
            start        <= start_n;
            retire       <= retire_n;
            stage_cycles <= stage_cycles_n;
            done_seen    <= done_seen_n;
            halted       <= (stage_n == ENC_HALT);
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer with default parameters. Each
// scenario task pushes hand-derived expected outputs as it drives stimulus,
// then drains the scoreboard against what the DUT produced.
module tb_stage_sequencer;

    logic       clk;
    logic       rst;
    logic       blocked;
    logic [4:0] done;
    logic [4:0] skip_mask;
    logic       halt_req;
    logic [2:0] stage;
    logic [4:0] start;
    logic       retire;
    logic [7:0] stage_cycles;
    logic       halted;

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] sb;
        logic       rt;
        logic [7:0] cy;
        logic       hl;
    } obs_t;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   vectors;
    int   miscompares;

    stage_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .blocked      (blocked),
        .done         (done),
        .skip_mask    (skip_mask),
        .halt_req     (halt_req),
        .stage        (stage),
        .start        (start),
        .retire       (retire),
        .stage_cycles (stage_cycles),
        .halted       (halted)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [2:0] st, input logic [4:0] sb,
                                input logic rt, input logic [7:0] cy, input logic hl);
        obs_t o;
        o.st = st;
        o.sb = sb;
        o.rt = rt;
        o.cy = cy;
        o.hl = hl;
        return o;
    endfunction

    // Apply one cycle of inputs, record the expectation and capture the result.
    task automatic drive_cycle(input logic r, input logic b, input logic [4:0] d,
                               input logic [4:0] s, input logic h, input obs_t e);
        obs_t g;
        rst       = r;
        blocked   = b;
        done      = d;
        skip_mask = s;
        halt_req  = h;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g.st = stage;
        g.sb = start;
        g.rt = retire;
        g.cy = stage_cycles;
        g.hl = halted;
        got_q.push_back(g);
    endtask

    task automatic test_reset();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b0, 1'b0, 5'h1f, 5'h00, 1'b1, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b1, 5'h1f, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b1, 5'h1f, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL reset step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_full_sequence();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd3, 5'b00100, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd4, 5'b01000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd5, 5'b10000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b1, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL full_sequence step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_wait_done();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd1, 5'b00000, 1'b0, 8'(k), 1'b0));
        end
        drive_cycle(1'b1, 1'b0, 5'h01, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd3, 5'b00100, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd4, 5'b01000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd4, 5'b00000, 1'b0, 8'd1, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL wait_done step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_saturation();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        for (int k = 1; k <= 300; k++) begin
            drive_cycle(1'b1, 1'b0, 5'h00, 5'h00, 1'b0,
                        mk(3'd1, 5'b00000, 1'b0, (k > 255) ? 8'd255 : 8'(k), 1'b0));
        end
        drive_cycle(1'b1, 1'b0, 5'h01, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL saturation step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_skip();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd3, 5'b00100, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd5, 5'b10000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd1, 5'b00001, 1'b1, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b01000, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b11110, 1'b0, mk(3'd1, 5'b00001, 1'b1, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b11110, 1'b0, mk(3'd1, 5'b00001, 1'b1, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b11111, 1'b0, mk(3'd1, 5'b00001, 1'b1, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'b00000, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL skip step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_blocked_done();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd3, 5'b00100, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd4, 5'b01000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b1, 5'b11111, 5'h00, 1'b0, mk(3'd4, 5'b00000, 1'b0, 8'd1, 1'b0));
        drive_cycle(1'b1, 1'b1, 5'b10111, 5'h00, 1'b0, mk(3'd4, 5'b00000, 1'b0, 8'd2, 1'b0));
        drive_cycle(1'b1, 1'b1, 5'b10111, 5'h00, 1'b0, mk(3'd4, 5'b00000, 1'b0, 8'd3, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd5, 5'b10000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b1, 8'd0, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL blocked_done step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_halt();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b1, mk(3'd3, 5'b00100, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b1, mk(3'd4, 5'b01000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b1, mk(3'd5, 5'b10000, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b1, mk(3'd7, 5'b00000, 1'b1, 8'd0, 1'b1));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b1, mk(3'd7, 5'b00000, 1'b0, 8'd1, 1'b1));
        drive_cycle(1'b1, 1'b1, 5'h1f, 5'h00, 1'b0, mk(3'd7, 5'b00000, 1'b0, 8'd2, 1'b1));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd1, 5'b00001, 1'b0, 8'd0, 1'b0));
        drive_cycle(1'b1, 1'b0, 5'h1f, 5'h00, 1'b0, mk(3'd2, 5'b00010, 1'b0, 8'd0, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL halt step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    task automatic test_reset_midstage();
        obs_t e, g;
        int   i;
        drive_cycle(1'b0, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'(k), 5'(1 << (k - 1)), 1'b0, 8'd0, 1'b0));
        end
        drive_cycle(1'b0, 1'b0, 5'b11111, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'(k), 5'(1 << (k - 1)), 1'b0, 8'd0, 1'b0));
        end
        drive_cycle(1'b1, 1'b1, 5'b11111, 5'h00, 1'b0, mk(3'd4, 5'b00000, 1'b0, 8'd1, 1'b0));
        drive_cycle(1'b0, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd0, 5'b00000, 1'b0, 8'd0, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'(k), 5'(1 << (k - 1)), 1'b0, 8'd0, 1'b0));
        end
        drive_cycle(1'b1, 1'b0, 5'b10111, 5'h00, 1'b0, mk(3'd4, 5'b00000, 1'b0, 8'd1, 1'b0));
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("[TB] FAIL reset_midstage step %0d: got stage=%0d start=%b retire=%b cycles=%0d halted=%b, want stage=%0d start=%b retire=%b cycles=%0d halted=%b",
                         i, g.st, g.sb, g.rt, g.cy, g.hl, e.st, e.sb, e.rt, e.cy, e.hl);
            end
            i++;
        end
    endtask

    // Run every scenario in turn, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        blocked     = 1'b0;
        done        = '0;
        skip_mask   = '0;
        halt_req    = 1'b0;
        $display("[TB] starting stage_sequencer scenarios");
        test_reset();
        test_full_sequence();
        test_wait_done();
        test_saturation();
        test_skip();
        test_blocked_done();
        test_halt();
        test_reset_midstage();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
